// File: rtl/mem_arb_if.sv
// mem_arb_if: pipeline-side and memory-side handshake signals of the unified memory arbiter
interface mem_arb_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            I_REQ_in;
    logic [AW-1:0]   I_ADDR_in;
    logic            I_BUSY_out;
    logic            I_RVALID_out;
    logic [DW-1:0]   I_RDATA_out;
    logic            D_REQ_in;
    logic            D_WE_in;
    logic [AW-1:0]   D_ADDR_in;
    logic [DW-1:0]   D_WDATA_in;
    logic [DW/8-1:0] D_BE_in;
    logic            D_BUSY_out;
    logic            D_RVALID_out;
    logic [DW-1:0]   D_RDATA_out;
    logic            M_REQ_out;
    logic            M_WE_out;
    logic [AW-1:0]   M_ADDR_out;
    logic [DW-1:0]   M_WDATA_out;
    logic [DW/8-1:0] M_BE_out;
    logic            M_GNT_in;
    logic            M_RVALID_in;
    logic [DW-1:0]   M_RDATA_in;

    modport slave (
        input  I_REQ_in, I_ADDR_in, D_REQ_in, D_WE_in, D_ADDR_in, D_WDATA_in, D_BE_in,
               M_GNT_in, M_RVALID_in, M_RDATA_in,
        output I_BUSY_out, I_RVALID_out, I_RDATA_out, D_BUSY_out, D_RVALID_out, D_RDATA_out,
               M_REQ_out, M_WE_out, M_ADDR_out, M_WDATA_out, M_BE_out
    );

    modport master (
        output I_REQ_in, I_ADDR_in, D_REQ_in, D_WE_in, D_ADDR_in, D_WDATA_in, D_BE_in,
               M_GNT_in, M_RVALID_in, M_RDATA_in,
        input  I_BUSY_out, I_RVALID_out, I_RDATA_out, D_BUSY_out, D_RVALID_out, D_RDATA_out,
               M_REQ_out, M_WE_out, M_ADDR_out, M_WDATA_out, M_BE_out
    );
endinterface

// File: rtl/mem_arb.sv
// mem_arb: single-outstanding arbiter of one memory port between instruction fetch and load/store
// Define MEM_ARB_RR_EN for round-robin on simultaneous requests; default is data-over-instruction priority.
module mem_arb #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input logic      CLK,
    input logic      RSTn,
    input logic      EN,
    mem_arb_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    // owner/last_owner: 1 = data side, 0 = instruction side
    state_t          state_q, state_d;
    logic            owner_q, owner_d, last_owner_q, last_owner_d;
    logic            m_req_q, m_req_d, we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW/8-1:0] be_q, be_d;
    logic            resp, sel_d, new_own, other_req, cap;

    // winner selection, capture of the winning request and next state
    always_comb begin
        resp      = (state_q == RESP) && bus.M_RVALID_in;
`ifdef MEM_ARB_RR_EN
        sel_d     = (bus.I_REQ_in && bus.D_REQ_in) ? !last_owner_q : bus.D_REQ_in;
`else
        sel_d     = bus.D_REQ_in;
`endif
        other_req = owner_q ? bus.I_REQ_in : bus.D_REQ_in;
        cap       = ((state_q == IDLE) && EN && (bus.I_REQ_in || bus.D_REQ_in)) || (resp && EN && other_req);
        new_own   = (state_q == IDLE) ? sel_d : !owner_q;
        owner_d   = cap ? new_own : owner_q;
        we_d      = cap ? (new_own && bus.D_WE_in) : we_q;
        addr_d    = cap ? (new_own ? bus.D_ADDR_in : bus.I_ADDR_in) : addr_q;
        wdata_d   = cap ? (new_own ? bus.D_WDATA_in : '0) : wdata_q;
        be_d      = cap ? (new_own ? bus.D_BE_in : '1) : be_q;
        last_owner_d = resp ? owner_q : last_owner_q;
        state_d   = cap ? ISSUE :
                    ((state_q == ISSUE) && bus.M_GNT_in) ? RESP :
                    resp ? IDLE : state_q;
        m_req_d   = (state_d == ISSUE);
    end

    // FSM state and registered memory-side outputs
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            m_req_q      <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            m_req_q      <= m_req_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
        end
    end

    assign bus.M_REQ_out    = m_req_q;
    assign bus.M_WE_out     = we_q;
    assign bus.M_ADDR_out   = addr_q;
    assign bus.M_WDATA_out  = wdata_q;
    assign bus.M_BE_out     = be_q;
    assign bus.I_RVALID_out = resp && !owner_q;
    assign bus.D_RVALID_out = resp && owner_q;
    assign bus.I_RDATA_out  = bus.I_RVALID_out ? bus.M_RDATA_in : '0;
    assign bus.D_RDATA_out  = bus.D_RVALID_out ? bus.M_RDATA_in : '0;
    assign bus.I_BUSY_out   = bus.I_REQ_in && !bus.I_RVALID_out;
    assign bus.D_BUSY_out   = bus.D_REQ_in && !bus.D_RVALID_out;
endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed table-driven bench for mem_arb plus reset and dropped-request sequences
module tb_mem_arb;
`ifdef MEM_ARB_RR_EN
    localparam bit W = 1'b1;
`else
    localparam bit W = 1'b0;
`endif
    // winner / loser of the simultaneous request after a completed data access
    localparam logic [31:0] WA  = W ? 32'h400 : 32'h500;
    localparam logic [31:0] LA  = W ? 32'h500 : 32'h400;
    localparam logic [31:0] WWD = W ? 32'h0 : 32'hAA;
    localparam logic [31:0] LWD = W ? 32'hAA : 32'h0;
    localparam logic [3:0]  WBE = W ? 4'hF : 4'hC;
    localparam logic [3:0]  LBE = W ? 4'hC : 4'hF;

    // fi = {en, i_req, d_req, d_we, gnt, rvalid}; fo = {m_req, m_we, i_busy, i_rvalid, d_busy, d_rvalid}
    typedef struct {
        logic [5:0]  fi;
        logic [31:0] ia, da, dwd;
        logic [3:0]  dbe;
        logic [31:0] rd;
        logic [5:0]  fo;
        logic [31:0] maddr, mwd;
        logic [3:0]  mbe;
    } vec_t;

    logic CLK = 1'b0;
    logic RSTn = 1'b1;
    logic EN = 1'b0;
    int checks = 0;
    int errors = 0;
    vec_t tab[$];

    always #5 CLK = ~CLK;

    mem_arb_if #(.AW(32), .DW(32)) bus ();
    mem_arb #(.AW(32), .DW(32)) dut (.CLK(CLK), .RSTn(RSTn), .EN(EN), .bus(bus));

    task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        {EN, bus.I_REQ_in, bus.D_REQ_in, bus.D_WE_in, bus.M_GNT_in, bus.M_RVALID_in} = v.fi;
        bus.I_ADDR_in  = v.ia;
        bus.D_ADDR_in  = v.da;
        bus.D_WDATA_in = v.dwd;
        bus.D_BE_in    = v.dbe;
        bus.M_RDATA_in = v.rd;
    endtask

    task automatic check_row(input vec_t v, input int r);
        chk("M_REQ", r, 32'(bus.M_REQ_out), 32'(v.fo[5]));
        chk("M_WE", r, 32'(bus.M_WE_out), 32'(v.fo[4]));
        chk("M_ADDR", r, bus.M_ADDR_out, v.maddr);
        chk("M_WDATA", r, bus.M_WDATA_out, v.mwd);
        chk("M_BE", r, 32'(bus.M_BE_out), 32'(v.mbe));
        chk("I_BUSY", r, 32'(bus.I_BUSY_out), 32'(v.fo[3]));
        chk("I_RVALID", r, 32'(bus.I_RVALID_out), 32'(v.fo[2]));
        chk("I_RDATA", r, bus.I_RDATA_out, v.fo[2] ? v.rd : 32'h0);
        chk("D_BUSY", r, 32'(bus.D_BUSY_out), 32'(v.fo[1]));
        chk("D_RVALID", r, 32'(bus.D_RVALID_out), 32'(v.fo[0]));
        chk("D_RDATA", r, bus.D_RDATA_out, v.fo[0] ? v.rd : 32'h0);
    endtask

    initial begin
        // isolated fetch
        tab.push_back('{6'b110000, 32'h100, 32'h0, 32'h0, 4'h0, 32'h0, 6'b001000, 32'h0, 32'h0, 4'h0});
        tab.push_back('{6'b110010, 32'h100, 32'h0, 32'h0, 4'h0, 32'h0, 6'b101000, 32'h100, 32'h0, 4'hF});
        tab.push_back('{6'b110001, 32'h100, 32'h0, 32'h0, 4'h0, 32'hDEADBEEF, 6'b000100, 32'h100, 32'h0, 4'hF});
        tab.push_back('{6'b100000, 32'h0, 32'h0, 32'h0, 4'h0, 32'h0, 6'b000000, 32'h100, 32'h0, 4'hF});
        // simultaneous store + fetch, then back-to-back fetch
        tab.push_back('{6'b111100, 32'h104, 32'h200, 32'h55, 4'h3, 32'h0, 6'b001010, 32'h100, 32'h0, 4'hF});
        tab.push_back('{6'b111110, 32'h104, 32'h200, 32'h55, 4'h3, 32'h0, 6'b111010, 32'h200, 32'h55, 4'h3});
        tab.push_back('{6'b111101, 32'h104, 32'h200, 32'h55, 4'h3, 32'h11111111, 6'b011001, 32'h200, 32'h55, 4'h3});
        tab.push_back('{6'b110010, 32'h104, 32'h0, 32'h0, 4'h0, 32'h0, 6'b101000, 32'h104, 32'h0, 4'hF});
        tab.push_back('{6'b110001, 32'h104, 32'h0, 32'h0, 4'h0, 32'h22222222, 6'b000100, 32'h104, 32'h0, 4'hF});
        tab.push_back('{6'b100000, 32'h0, 32'h0, 32'h0, 4'h0, 32'h0, 6'b000000, 32'h104, 32'h0, 4'hF});
        // load with a 5-cycle grant stall; stale response in IDLE ignored
        tab.push_back('{6'b101000, 32'h0, 32'h300, 32'h0, 4'hF, 32'h0, 6'b000010, 32'h104, 32'h0, 4'hF});
        for (int i = 0; i < 5; i++)
            tab.push_back('{6'b101000, 32'h0, 32'h300, 32'h0, 4'hF, 32'h0, 6'b100010, 32'h300, 32'h0, 4'hF});
        tab.push_back('{6'b101010, 32'h0, 32'h300, 32'h0, 4'hF, 32'h0, 6'b100010, 32'h300, 32'h0, 4'hF});
        tab.push_back('{6'b101001, 32'h0, 32'h300, 32'h0, 4'hF, 32'h33333333, 6'b000001, 32'h300, 32'h0, 4'hF});
        tab.push_back('{6'b100001, 32'h0, 32'h0, 32'h0, 4'h0, 32'h44444444, 6'b000000, 32'h300, 32'h0, 4'hF});
        // simultaneous requests after a completed data access
        tab.push_back('{6'b111100, 32'h400, 32'h500, 32'hAA, 4'hC, 32'h0, 6'b001010, 32'h300, 32'h0, 4'hF});
        tab.push_back('{6'b111110, 32'h400, 32'h500, 32'hAA, 4'hC, 32'h0, {1'b1, !W, 4'b1010}, WA, WWD, WBE});
        tab.push_back('{6'b111101, 32'h400, 32'h500, 32'hAA, 4'hC, 32'h5555, {1'b0, !W, !W, W, W, !W}, WA, WWD, WBE});
        tab.push_back('{6'b111110, 32'h400, 32'h500, 32'hAA, 4'hC, 32'h0, {1'b1, W, 4'b1010}, LA, LWD, LBE});
        tab.push_back('{{1'b1, !W, W, 3'b101}, 32'h400, 32'h500, 32'hAA, 4'hC, 32'h6666, {1'b0, W, 1'b0, !W, 1'b0, W}, LA, LWD, LBE});
        tab.push_back('{6'b100000, 32'h0, 32'h0, 32'h0, 4'h0, 32'h0, {1'b0, W, 4'b0000}, LA, LWD, LBE});
        // EN low blocks the grant, then EN falls mid-transaction
        for (int i = 0; i < 4; i++)
            tab.push_back('{6'b010000, 32'h600, 32'h0, 32'h0, 4'h0, 32'h0, {1'b0, W, 4'b1000}, LA, LWD, LBE});
        tab.push_back('{6'b110000, 32'h600, 32'h0, 32'h0, 4'h0, 32'h0, {1'b0, W, 4'b1000}, LA, LWD, LBE});
        tab.push_back('{6'b110000, 32'h600, 32'h0, 32'h0, 4'h0, 32'h0, 6'b101000, 32'h600, 32'h0, 4'hF});
        tab.push_back('{6'b010010, 32'h600, 32'h0, 32'h0, 4'h0, 32'h0, 6'b101000, 32'h600, 32'h0, 4'hF});
        tab.push_back('{6'b010001, 32'h600, 32'h0, 32'h0, 4'h0, 32'h7777, 6'b000100, 32'h600, 32'h0, 4'hF});
        tab.push_back('{6'b100000, 32'h0, 32'h0, 32'h0, 4'h0, 32'h0, 6'b000000, 32'h600, 32'h0, 4'hF});

        drive('{6'b0, 32'h0, 32'h0, 32'h0, 4'h0, 32'h0, 6'b0, 32'h0, 32'h0, 4'h0});
        #1 RSTn = 1'b0;
        #1;
        chk("rst M_REQ", -1, 32'(bus.M_REQ_out), 32'h0);
        chk("rst M_WE", -1, 32'(bus.M_WE_out), 32'h0);
        chk("rst M_ADDR", -1, bus.M_ADDR_out, 32'h0);
        chk("rst M_WDATA", -1, bus.M_WDATA_out, 32'h0);
        chk("rst M_BE", -1, 32'(bus.M_BE_out), 32'h0);
        @(negedge CLK) RSTn = 1'b1;

        foreach (tab[r]) begin
            @(negedge CLK);
            drive(tab[r]);
            #1 check_row(tab[r], r);
        end

        // async reset while in ISSUE
        @(negedge CLK);
        EN = 1'b1; bus.I_REQ_in = 1'b1; bus.I_ADDR_in = 32'h730;
        #1 chk("seqA I_BUSY", 100, 32'(bus.I_BUSY_out), 32'h1);
        @(negedge CLK);
        #1 chk("seqA M_REQ", 101, 32'(bus.M_REQ_out), 32'h1);
        chk("seqA M_ADDR", 101, bus.M_ADDR_out, 32'h730);
        #2 RSTn = 1'b0;
        #1 chk("seqA rst M_REQ", 102, 32'(bus.M_REQ_out), 32'h0);
        chk("seqA rst M_ADDR", 102, bus.M_ADDR_out, 32'h0);
        @(negedge CLK);
        RSTn = 1'b1; bus.I_REQ_in = 1'b0;

        // async reset while in RESP, then a stale response
        @(negedge CLK);
        bus.I_REQ_in = 1'b1; bus.I_ADDR_in = 32'h740;
        @(negedge CLK);
        bus.M_GNT_in = 1'b1;
        #1 chk("seqB M_REQ", 110, 32'(bus.M_REQ_out), 32'h1);
        @(negedge CLK);
        bus.M_GNT_in = 1'b0;
        #1 chk("seqB resp M_REQ", 111, 32'(bus.M_REQ_out), 32'h0);
        chk("seqB resp M_ADDR", 111, bus.M_ADDR_out, 32'h740);
        #2 RSTn = 1'b0;
        #1 chk("seqB rst M_ADDR", 112, bus.M_ADDR_out, 32'h0);
        chk("seqB rst M_BE", 112, 32'(bus.M_BE_out), 32'h0);
        @(negedge CLK);
        RSTn = 1'b1; bus.I_REQ_in = 1'b0; bus.M_RVALID_in = 1'b1; bus.M_RDATA_in = 32'h88;
        #1 chk("seqB stale I_RVALID", 113, 32'(bus.I_RVALID_out), 32'h0);
        chk("seqB stale I_RDATA", 113, bus.I_RDATA_out, 32'h0);
        chk("seqB stale D_RVALID", 113, 32'(bus.D_RVALID_out), 32'h0);
        @(negedge CLK);
        #1 chk("seqB stale2 I_RVALID", 114, 32'(bus.I_RVALID_out), 32'h0);
        chk("seqB stale2 M_REQ", 114, 32'(bus.M_REQ_out), 32'h0);

        // requester drops REQ before its response
        @(negedge CLK);
        bus.M_RVALID_in = 1'b0; bus.I_REQ_in = 1'b1; bus.I_ADDR_in = 32'h750;
        @(negedge CLK);
        bus.M_GNT_in = 1'b1;
        #1 chk("seqC M_REQ", 120, 32'(bus.M_REQ_out), 32'h1);
        chk("seqC M_ADDR", 120, bus.M_ADDR_out, 32'h750);
        @(negedge CLK);
        bus.M_GNT_in = 1'b0; bus.I_REQ_in = 1'b0;
        #1 chk("seqC I_BUSY", 121, 32'(bus.I_BUSY_out), 32'h0);
        chk("seqC early I_RVALID", 121, 32'(bus.I_RVALID_out), 32'h0);
        @(negedge CLK);
        bus.M_RVALID_in = 1'b1; bus.M_RDATA_in = 32'h99;
        #1 chk("seqC I_RVALID", 122, 32'(bus.I_RVALID_out), 32'h1);
        chk("seqC I_RDATA", 122, bus.I_RDATA_out, 32'h99);
        @(negedge CLK);
        bus.M_RVALID_in = 1'b0; bus.I_REQ_in = 1'b1; bus.I_ADDR_in = 32'h760;
        #1 chk("seqC idle M_REQ", 123, 32'(bus.M_REQ_out), 32'h0);
        @(negedge CLK);
        #1 chk("seqC next M_REQ", 124, 32'(bus.M_REQ_out), 32'h1);
        chk("seqC next M_ADDR", 124, bus.M_ADDR_out, 32'h760);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arb.md
Name: mem_arb

Overview:
- Arbitrates a single unified memory port between the IF-stage instruction fetcher and the MEM-stage load/store unit.
- Allows at most one outstanding transaction.
- Drives per-requester busy flags; the hazard unit consumes these to stall the pipeline.
- Sits between the pipeline stages and the external memory/bus interface.

Parameters:
AW, 32, address width in bits
DW, 32, data width in bits; must be a multiple of 8

Ports:
CLK  in  1  clock, rising edge
RSTn  in  1  asynchronous, active-low reset
EN  in  1  arbiter enable; when low, no new grant is made
I_REQ_in  in  1  instruction fetch request; held until I_RVALID_out
I_ADDR_in  in  AW  fetch address; stable while I_REQ_in is high
I_BUSY_out  out  1  instruction side stalled
I_RVALID_out  out  1  fetch data valid, one-cycle pulse
I_RDATA_out  out  DW  fetch data
D_REQ_in  in  1  data request; held until D_RVALID_out
D_WE_in  in  1  1 = store, 0 = load
D_ADDR_in  in  AW  data address
D_WDATA_in  in  DW  store data
D_BE_in  in  DW/8  byte enables
D_BUSY_out  out  1  data side stalled
D_RVALID_out  out  1  load data valid / store done, one-cycle pulse
D_RDATA_out  out  DW  load data
M_REQ_out  out  1  memory request
M_WE_out  out  1  memory write enable
M_ADDR_out  out  AW  memory address
M_WDATA_out  out  DW  memory write data
M_BE_out  out  DW/8  memory byte enables
M_GNT_in  in  1  memory accepts the request this cycle
M_RVALID_in  in  1  response valid (reads and writes)
M_RDATA_in  in  DW  read data

Behaviour:
- FSM states: IDLE, ISSUE, RESP.
  - Registers: owner (I/D), last_owner, captured request (we, addr, wdata, be).
- Reset (async, RSTn low):
  - State goes to IDLE; owner = I; last_owner = D.
  - M_REQ_out, M_WE_out, M_ADDR_out, M_WDATA_out and M_BE_out are all 0.
- IDLE:
  - If EN and any REQ is high, select a winner and capture its fields. Next state is ISSUE.
  - Instruction captures: we=0, be=all ones, wdata=0.
  - Default priority: D wins over I when both request.
  - If EN is low, stay in IDLE.
  - M_RVALID_in is ignored in IDLE, including stale responses after a reset.
- ISSUE:
  - M_REQ_out=1; M_* outputs are driven from the captured registers and are stable until the grant.
  - M_GNT_in=1: go to RESP and drop M_REQ_out the next cycle.
  - M_GNT_in=0: hold. There is no timeout.
  - M_RVALID_in is ignored in ISSUE.
- RESP:
  - Wait for M_RVALID_in.
  - On M_RVALID_in, the owner's RVALID_out=1 and RDATA_out=M_RDATA_in, combinationally in the same cycle; last_owner <= owner.
  - If the non-owner's REQ is high and EN=1 in that cycle: capture it and go directly to ISSUE (back-to-back).
  - Otherwise go to IDLE.
  - The owner's REQ is not re-arbitrated in the RVALID cycle.
- RDATA_out:
  - Equals M_RDATA_in only when RVALID_out is high; otherwise 0.
  - The non-owner's RDATA_out is always 0.
- BUSY_out:
  - I_BUSY_out = I_REQ_in and not I_RVALID_out. D_BUSY_out is defined the same way.
  - Both are combinational, so a requester is busy from its REQ cycle through the cycle before its response.
- Latency:
  - REQ in cycle 0 (IDLE), M_REQ_out in cycle 1, earliest response in cycle 2.
  - Minimum of 3 cycles per isolated access; back-to-back accesses cost 2 cycles each.
- EN falling mid-transaction: the in-flight access completes; only new grants are blocked.
- Requester dropping REQ before its response: the response is still delivered as an RVALID pulse and the arbiter returns to IDLE. This is a protocol violation but must not hang.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: on a simultaneous request in IDLE, the requester that is not last_owner wins (round-robin). The RESP back-to-back rule is unchanged.
- Undefined: fixed data-over-instruction priority, and last_owner is unused.

Test Plan:
- Isolated fetch: I_REQ_in=1 with I_ADDR_in=0x100, M_GNT_in=1 immediately, M_RVALID_in in cycle 2 with M_RDATA_in=0xDEADBEEF.
  - Expect M_REQ_out high in cycle 1 with M_ADDR_out=0x100 and M_WE_out=0.
  - Expect I_RVALID_out=1 with I_RDATA_out=0xDEADBEEF in cycle 2.
  - Expect I_BUSY_out high in cycles 0-1.
- Simultaneous requests (macro off): I_REQ_in and D_REQ_in rise in the same cycle, with a store D_ADDR_in=0x200, D_WDATA_in=0x55, D_BE_in=4'b0011.
  - Expect the data access issued first with M_WE_out=1 and M_BE_out=4'b0011.
  - Expect the fetch issued back-to-back in the cycle after D_RVALID_out.
- Grant stall: hold M_GNT_in=0 for 5 cycles.
  - Expect M_REQ_out and M_ADDR_out stable for all 5 cycles.
  - Expect BUSY_out to remain high; a single response follows the grant.
- Async reset in RESP: pulse RSTn low mid-cycle.
  - Expect M_REQ_out=0 immediately and the state to return to IDLE.
  - A following M_RVALID_in produces no RVALID_out.
- EN low with I_REQ_in=1 for 4 cycles.
  - Expect no M_REQ_out and I_BUSY_out=1 throughout.
  - After EN rises, expect M_REQ_out the next cycle.
- MEM_ARB_RR_EN defined: after a completed data access, both requesters request simultaneously.
  - Expect the instruction side granted first.
